// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the core pipeline and the multiply/divide unit.
interface muldiv_if #(parameter int N = 32);

    logic         start_i;
    logic [2:0]   op_i;
    logic [N-1:0] rs1_data_i;
    logic [N-1:0] rs2_data_i;
    logic [4:0]   rd_addr_i;
    logic         flush_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] result_o;
    logic [4:0]   rd_addr_o;

    modport master (
        output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
        input  busy_o, done_o, result_o, rd_addr_o
    );

    modport slave (
        input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
        output busy_o, done_o, result_o, rd_addr_o
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shared shift-add / restoring-divide step per cycle.
//   state     | meaning
//   ST_IDLE   | waiting for start_i; operands latched on accept
//   ST_BUSY   | one multiply or divide iteration per cycle
//   ST_FINISH | sign fix, result select, done_o pulse
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int CW = cnt_width(N);

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [4:0]    rd_q, rd_out_q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  acc_hi, acc_lo, opb;
    logic          neg_res, neg_rem;
    logic [N-1:0]  res_q, res_fin;

    logic          is_div, a_signed, b_signed, a_neg, b_neg;
    logic          div_zero, div_ovf, accept, fin_valid;
    logic [N-1:0]  a_mag, b_mag;
    logic [N:0]    mul_sum, div_shift, div_diff;
    logic [2*N-1:0] prod, prod_fix;
    logic [N-1:0]  quo_fix, rem_fix;

    always_comb begin
        is_div   = bus.op_i[2];
        a_signed = (bus.op_i != OP_MULHU) && (bus.op_i != OP_DIVU) && (bus.op_i != OP_REMU);
        b_signed = a_signed && (bus.op_i != OP_MULHSU);
        a_neg    = a_signed && bus.rs1_data_i[N-1];
        b_neg    = b_signed && bus.rs2_data_i[N-1];
        a_mag    = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
        b_mag    = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
        div_zero = is_div && (bus.rs2_data_i == '0);
        div_ovf  = is_div && !bus.op_i[0] && (bus.rs1_data_i == {1'b1, {(N-1){1'b0}}})
                   && (&bus.rs2_data_i);
        accept   = (state == ST_IDLE) && bus.start_i && !bus.flush_i;
    end

    // Multiply keeps the multiplier in acc_lo and shifts product bits into it;
    // divide keeps the dividend in acc_lo and shifts quotient bits into it.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[N-1]};
        div_diff  = div_shift - {1'b0, opb};
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi : acc_hi;
        res_fin  = '0;
        case (op_q)
            OP_MUL:                       res_fin = prod_fix[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_fin = prod_fix[2*N-1:N];
            OP_DIV, OP_DIVU:              res_fin = quo_fix;
            default:                      res_fin = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (bus.start_i) state_nxt = (div_zero || div_ovf) ? ST_FINISH : ST_BUSY;
                ST_BUSY:   if (cnt == CW'(1)) state_nxt = ST_FINISH;
                ST_FINISH: state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            res_q    <= '0;
        end else begin
            if (accept) begin
                op_q <= bus.op_i;
                rd_q <= bus.rd_addr_i;
                cnt  <= CW'(N);
                opb  <= b_mag;
                if (div_zero) begin
                    // Special results are preloaded so FINISH selects them with no sign fix.
                    acc_lo  <= '1;
                    acc_hi  <= bus.rs1_data_i;
                    neg_res <= 1'b0;
                    neg_rem <= 1'b0;
                end else if (div_ovf) begin
                    acc_lo  <= bus.rs1_data_i;
                    acc_hi  <= '0;
                    neg_res <= 1'b0;
                    neg_rem <= 1'b0;
                end else begin
                    acc_lo  <= a_mag;
                    acc_hi  <= '0;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                end
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CW'(1);
                if (op_q[2]) begin
                    acc_hi <= div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0];
                    acc_lo <= {acc_lo[N-2:0], ~div_diff[N]};
                end else begin
                    acc_hi <= mul_sum[N:1];
                    acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
                end
            end
            if (fin_valid) begin
                res_q    <= res_fin;
                rd_out_q <= rd_q;
            end
        end
    end

    assign fin_valid     = (state == ST_FINISH) && !bus.flush_i;
    assign bus.busy_o    = (state != ST_IDLE);
    assign bus.done_o    = fin_valid;
    assign bus.result_o  = fin_valid ? res_fin : res_q;
    assign bus.rd_addr_o = fin_valid ? rd_q : rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed expected results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.N(32)) bus();
    muldiv_unit #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ikind: 0 none, 1 stray start pulse at cycle icyc, 2 flush at cycle icyc
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_lat, input int icyc, input int ikind);
        int dones, first;
        logic [31:0] got_res;
        logic [4:0]  got_rd;
        logic busy1, busy_after;
        dones = 0; first = 0; got_res = '0; got_rd = '0; busy1 = 1'b0; busy_after = 1'b1;
        @(negedge clk);
        bus.op_i = op; bus.rs1_data_i = a; bus.rs2_data_i = b; bus.rd_addr_i = rd;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.rs1_data_i = ~a; bus.rs2_data_i = b + 32'd3; bus.rd_addr_i = ~rd;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == icyc && ikind == 1) begin
                bus.start_i = 1'b1; bus.op_i = OP_MUL;
                bus.rs1_data_i = 32'd9; bus.rs2_data_i = 32'd9; bus.rd_addr_i = 5'd30;
            end
            if (cyc == icyc && ikind == 2) bus.flush_i = 1'b1;
            @(negedge clk);
            if (cyc == 1) busy1 = bus.busy_o;
            if (cyc == icyc + 1) busy_after = bus.busy_o;
            if (bus.done_o) begin
                dones++;
                if (first == 0) begin
                    first = cyc; got_res = bus.result_o; got_rd = bus.rd_addr_o;
                end
            end
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            bus.flush_i = 1'b0;
        end
        chk({tag, " busy"}, busy1, 1);
        if (ikind == 2) begin
            chk({tag, " dones"}, dones, 0);
            chk({tag, " busy_after_flush"}, busy_after, 0);
            chk({tag, " res_held"}, bus.result_o, last_res);
            chk({tag, " rd_held"}, bus.rd_addr_o, last_rd);
        end else begin
            chk({tag, " dones"}, dones, 1);
            chk({tag, " latency"}, first, exp_lat);
            chk({tag, " result"}, got_res, exp_res);
            chk({tag, " rd"}, got_rd, rd);
            chk({tag, " res_hold"}, bus.result_o, exp_res);
            last_res = exp_res;
            last_rd  = rd;
        end
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.op_i = '0; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
        bus.rd_addr_i = '0; bus.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", bus.busy_o, 0);
        chk("reset done", bus.done_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset result", bus.result_o, 0);
        chk("reset rd", bus.rd_addr_o, 0);

        run_op("mul",       OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 0, 0);
        run_op("mul_lo",    OP_MUL,    32'h1234_5678, 32'h10,       5'd6,  32'h2345_6780, 33, 0, 0);
        run_op("mulh",      OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 33, 0, 0);
        run_op("mulhu",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 33, 0, 0);
        run_op("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFF, 33, 0, 0);
        run_op("div",       OP_DIV,    32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFD, 33, 0, 0);
        run_op("rem",       OP_REM,    32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFF, 33, 0, 0);
        run_op("div_negb",  OP_DIV,    32'd7,        32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33, 0, 0);
        run_op("rem_negb",  OP_REM,    32'd7,        32'hFFFF_FFFE, 5'd13, 32'd1,         33, 0, 0);
        run_op("divu",      OP_DIVU,   32'd100,      32'd7,         5'd14, 32'd14,        33, 0, 0);
        run_op("remu",      OP_REMU,   32'd100,      32'd7,         5'd15, 32'd2,         33, 0, 0);
        run_op("divu_big",  OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,        33, 0, 0);
        run_op("remu_big",  OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 33, 0, 0);
        run_op("divu_zero", OP_DIVU,   32'h1234,     32'd0,         5'd18, 32'hFFFF_FFFF, 1, 0, 0);
        run_op("rem_zero",  OP_REM,    32'h1234,     32'd0,         5'd19, 32'h1234,      1, 0, 0);
        run_op("div_ovf",   OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1, 0, 0);
        run_op("rem_ovf",   OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,        1, 0, 0);
        run_op("div_start_ignored", OP_DIV, 32'd100, 32'd7, 5'd3, 32'd14, 33, 10, 1);
        run_op("mul_flush", OP_MUL, 32'd5, 32'd6, 5'd4, 32'd0, 0, 5, 2);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.op_i = OP_MUL; bus.rs1_data_i = 32'h1234; bus.rs2_data_i = 32'h10;
        bus.rd_addr_i = 5'd9; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst busy", bus.busy_o, 0);
        chk("midrst done", bus.done_o, 0);
        chk("midrst result", bus.result_o, 0);
        chk("midrst rd", bus.rd_addr_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        last_rd  = '0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        chk("midrst no_done", dones, 0);
        run_op("mul_after_rst", OP_MUL, 32'd1000, 32'd1000, 5'd22, 32'd1000000, 33, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
